// File: rtl/acia_fifo_pkg.sv
// rtl/acia_fifo_pkg.sv - shared constants, state encodings and divisor helper for acia_fifo
package acia_fifo_pkg;

  localparam logic [1:0] ADDR_CTRL  = 2'd0;
  localparam logic [1:0] ADDR_DATA  = 2'd1;
  localparam logic [1:0] ADDR_DIVLO = 2'd2;
  localparam logic [1:0] ADDR_DIVHI = 2'd3;

  localparam int CTRL_RIE     = 7;
  localparam int CTRL_TC_HI   = 6;
  localparam int CTRL_TC_LO   = 5;
  localparam int CTRL_LOOP    = 4;
  localparam int CTRL_RXTH_HI = 3;
  localparam int CTRL_RXTH_LO = 2;
  localparam int CTRL_CDS_HI  = 1;
  localparam int CTRL_CDS_LO  = 0;

  localparam int ST_IRQ     = 7;
  localparam int ST_OVRN    = 5;
  localparam int ST_FE      = 4;
  localparam int ST_TX_IDLE = 3;
  localparam int ST_RX_GE   = 2;
  localparam int ST_TX_NF   = 1;
  localparam int ST_RX_NE   = 0;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // Rounded divisor for a 16x oversampling tick, minus one for the down-counter reload.
  function automatic logic [15:0] default_div(input int unsigned clk_hz, input int unsigned baud);
    int unsigned den;
    den = 16 * baud;
    return 16'(((clk_hz + den / 2) / den) - 1);
  endfunction

endpackage

// File: rtl/acia_sync_fifo.sv
// rtl/acia_sync_fifo.sv - synchronous FIFO with flush; a pop frees room for a same-cycle push
module acia_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop & ~empty;
    push_ok  = push & (~full | pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok) count_d = count_q + 1'b1;
      if (pop_ok && !push_ok) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/acia_fifo.sv
// rtl/acia_fifo.sv - 6850-style ACIA with TX/RX FIFOs, 16-bit baud divisor and sticky error flags
// Optional ACIA_FIFO_LOOPBACK_EN: control[4] feeds the TX line into the RX synchroniser.
module acia_fifo
  import acia_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int SYS_CLK_FREQ = 16000000,
  parameter int BAUD_RATE    = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       rx,
  output logic       tx,
  output logic       irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] RESET_DIV = default_div(SYS_CLK_FREQ, BAUD_RATE);
  localparam int TH_Q = (FIFO_DEPTH / 4 < 1) ? 1 : FIFO_DEPTH / 4;
  localparam int TH_H = FIFO_DEPTH / 2;
  localparam int TH_N = (FIFO_DEPTH - 2 < 1) ? 1 : FIFO_DEPTH - 2;

  logic [7:0]  ctrl_q, ctrl_d, dout_q, dout_d, last_rx_q, last_rx_d;
  logic [15:0] div_q, div_d, baud_q, baud_d;
  logic        ovr_q, ovr_d, fe_q, fe_d;
  tx_state_e   tx_state_q, tx_state_d;
  logic [3:0]  tx_tick_q, tx_tick_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  rx_state_e   rx_state_q, rx_state_d;
  logic [3:0]  rx_tick_q, rx_tick_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;

  logic          mreset, tick16, tx_line, rx_src, tx_idle, rx_ge, irq_w;
  logic          tx_push, tx_pop, rx_push, rx_pop, err_clr, ovr_set, fe_set;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0]    tx_head, rx_head, status;
  logic [CW-1:0] rx_count, rx_th, unused_tx_count;

  acia_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk(clk), .rst(rst), .flush(mreset), .push(tx_push), .pop(tx_pop), .wdata(din),
    .rdata(tx_head), .full(tx_full), .empty(tx_empty), .count(unused_tx_count)
  );

  acia_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk(clk), .rst(rst), .flush(mreset), .push(rx_push), .pop(rx_pop), .wdata(rx_shift_q),
    .rdata(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  assign mreset  = (ctrl_q[CTRL_CDS_HI:CTRL_CDS_LO] == 2'b11);
  assign tick16  = (baud_q == 16'd0);
  assign tx_idle = tx_empty & (tx_state_q == TX_IDLE);
  assign rx_ge   = (rx_count >= rx_th);
  assign irq_w   = (ctrl_q[CTRL_RIE] & (rx_ge | ovr_q | fe_q))
                 | ((ctrl_q[CTRL_TC_HI:CTRL_TC_LO] == 2'b01) & ~tx_full);
  assign irq     = irq_w;
  assign dout    = dout_q;

`ifdef ACIA_FIFO_LOOPBACK_EN
  assign rx_src = ctrl_q[CTRL_LOOP] ? tx_line : rx;
  assign tx     = ctrl_q[CTRL_LOOP] ? 1'b1 : tx_line;
`else
  logic unused_loop;
  assign unused_loop = ctrl_q[CTRL_LOOP];
  assign rx_src = rx;
  assign tx     = tx_line;
`endif

  always_comb begin
    case (ctrl_q[CTRL_RXTH_HI:CTRL_RXTH_LO])
      2'd0:    rx_th = CW'(1);
      2'd1:    rx_th = CW'(TH_Q);
      2'd2:    rx_th = CW'(TH_H);
      default: rx_th = CW'(TH_N);
    endcase
  end

  // CPU bus: register writes, data push/pop, registered read data.
  always_comb begin
    status  = {irq_w, 1'b0, ovr_q, fe_q, tx_idle, rx_ge, ~tx_full, ~rx_empty};
    ctrl_d  = ctrl_q;
    div_d   = div_q;
    dout_d  = dout_q;
    tx_push = 1'b0;
    rx_pop  = 1'b0;
    err_clr = 1'b0;
    if (cs && we) begin
      case (addr)
        ADDR_CTRL:  ctrl_d = din;
        ADDR_DATA:  tx_push = 1'b1;
        ADDR_DIVLO: div_d[7:0] = din;
        default:    div_d[15:8] = din;
      endcase
    end
    if (cs && !we) begin
      case (addr)
        ADDR_CTRL: dout_d = status;
        ADDR_DATA: begin
          err_clr = 1'b1;
          rx_pop  = ~rx_empty;
          dout_d  = rx_empty ? last_rx_q : rx_head;
        end
        ADDR_DIVLO: dout_d = div_q[7:0];
        default:    dout_d = div_q[15:8];
      endcase
    end
    last_rx_d = rx_pop ? rx_head : last_rx_q;
    ovr_d     = ~mreset & (ovr_set | (ovr_q & ~err_clr));
    fe_d      = ~mreset & (fe_set | (fe_q & ~err_clr));
    baud_d    = tick16 ? div_q : baud_q - 16'd1;
  end

  // TX engine: frames start on a tick so every bit is exactly 16 ticks wide.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_START: tx_line = 1'b0;
      TX_DATA:  tx_line = tx_shift_q[0];
      default:  tx_line = 1'b1;
    endcase
    if (mreset) tx_line = 1'b1;
    if (mreset) begin
      tx_state_d = TX_IDLE;
      tx_tick_d  = 4'd0;
      tx_bit_d   = 3'd0;
    end else if (tick16) begin
      case (tx_state_q)
        TX_IDLE: begin
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_head;
            tx_state_d = TX_START;
            tx_tick_d  = 4'd0;
          end
        end
        default: begin
          tx_tick_d = tx_tick_q + 4'd1;
          if (tx_tick_q == 4'd15) begin
            case (tx_state_q)
              TX_START: begin
                tx_state_d = TX_DATA;
                tx_bit_d   = 3'd0;
              end
              TX_DATA: begin
                tx_shift_d = {1'b0, tx_shift_q[7:1]};
                tx_bit_d   = tx_bit_q + 3'd1;
                if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
              end
              default: begin
                tx_state_d = tx_empty ? TX_IDLE : TX_START;
                tx_pop     = ~tx_empty;
                if (!tx_empty) tx_shift_d = tx_head;
              end
            endcase
          end
        end
      endcase
    end
  end

  // RX engine: start confirmed 8 ticks after detection, then each bit sampled 16 ticks apart.
  always_comb begin
    rx_s1_d    = rx_src;
    rx_s2_d    = rx_s1_q;
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    ovr_set    = 1'b0;
    fe_set     = 1'b0;
    if (mreset) begin
      rx_state_d = RX_IDLE;
      rx_tick_d  = 4'd0;
      rx_bit_d   = 3'd0;
    end else if (tick16) begin
      rx_tick_d = rx_tick_q + 4'd1;
      case (rx_state_q)
        RX_IDLE: begin
          rx_tick_d = 4'd0;
          if (!rx_s2_q) rx_state_d = RX_START;
        end
        RX_START: begin
          if (rx_tick_q == 4'd7) begin
            rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
            rx_tick_d  = 4'd0;
            rx_bit_d   = 3'd0;
          end
        end
        RX_DATA: begin
          if (rx_tick_q == 4'd15) begin
            rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
            rx_bit_d   = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          end
        end
        default: begin
          if (rx_tick_q == 4'd15) begin
            rx_state_d = RX_IDLE;
            fe_set     = ~rx_s2_q;
            ovr_set    = rx_s2_q & rx_full & ~rx_pop;
            rx_push    = rx_s2_q & ~(rx_full & ~rx_pop);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q     <= 8'h00;
      div_q      <= RESET_DIV;
      baud_q     <= RESET_DIV;
      dout_q     <= 8'h00;
      last_rx_q  <= 8'h00;
      ovr_q      <= 1'b0;
      fe_q       <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_tick_q  <= 4'd0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      rx_state_q <= RX_IDLE;
      rx_tick_q  <= 4'd0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
    end else begin
      ctrl_q     <= ctrl_d;
      div_q      <= div_d;
      baud_q     <= baud_d;
      dout_q     <= dout_d;
      last_rx_q  <= last_rx_d;
      ovr_q      <= ovr_d;
      fe_q       <= fe_d;
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      rx_state_q <= rx_state_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
    end
  end

endmodule

// File: tb/tb_acia_fifo.sv
// tb/tb_acia_fifo.sv - directed self-checking bench for acia_fifo at default parameters
module tb_acia_fifo;
  localparam int BIT = 144;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs = 1'b0;
  logic       we = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] din = 8'h00;
  logic       rx = 1'b1;
  logic [7:0] dout;
  logic       tx;
  logic       irq;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] rd;
  logic [19:0] exp_bits;
  logic       first_v, last_v;

  acia_fifo dut (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .din(din),
    .dout(dout), .rx(rx), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = a; din = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    cs = 1'b0;
    d = dout;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic wait_tx_low(input string tag);
    int n = 0;
    while (tx !== 1'b0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check(tag, {7'b0, tx}, 8'h00);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_dout", dout, 8'h00);
    check("rst_tx", {7'b0, tx}, 8'h01);
    check("rst_irq", {7'b0, irq}, 8'h00);
    bus_read(2'd0, rd); check("rst_status", rd, 8'h0A);
    bus_read(2'd2, rd); check("rst_div_lo", rd, 8'h08);
    bus_read(2'd3, rd); check("rst_div_hi", rd, 8'h00);

    // Two back-to-back TX frames, each bit checked at its first and last clock.
    bus_write(2'd2, 8'h08);
    bus_write(2'd3, 8'h00);
    bus_write(2'd1, 8'h55);
    bus_write(2'd1, 8'hA3);
    exp_bits = {1'b1, 8'hA3, 1'b0, 1'b1, 8'h55, 1'b0};
    wait_tx_low("tx_start");
    for (int i = 0; i < 20; i++) begin
      first_v = tx;
      repeat (BIT - 1) @(negedge clk);
      last_v = tx;
      check($sformatf("tx_bit%0d", i), {6'b0, first_v, last_v}, {6'b0, exp_bits[i], exp_bits[i]});
      @(negedge clk);
    end
    bus_read(2'd0, rd); check("tx_done_status", rd, 8'h0A);

    // 17 frames into a 16-deep RX FIFO.
    for (int i = 1; i <= 17; i++) send_rx(8'(i), 1'b1);
    repeat (20) @(negedge clk);
    bus_read(2'd0, rd); check("ovr_status", rd, 8'h2F);
    for (int i = 1; i <= 16; i++) begin
      bus_read(2'd1, rd); check($sformatf("rx_data%0d", i), rd, 8'(i));
      if (i == 1) begin
        bus_read(2'd0, rd); check("ovr_cleared", rd, 8'h0F);
      end
    end
    bus_read(2'd0, rd); check("rx_drained", rd, 8'h0A);
    bus_read(2'd1, rd); check("stale_head", rd, 8'h10);

    // Framing error, then a short glitch.
    send_rx(8'h5A, 1'b0);
    repeat (300) @(negedge clk);
    bus_read(2'd0, rd); check("fe_status", rd, 8'h1A);
    bus_read(2'd1, rd); check("fe_read_stale", rd, 8'h10);
    bus_read(2'd0, rd); check("fe_cleared", rd, 8'h0A);
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (400) @(negedge clk);
    bus_read(2'd0, rd); check("glitch_status", rd, 8'h0A);

    // RX threshold interrupt at DEPTH/2.
    bus_write(2'd0, 8'h88);
    check("irq_th_empty", {7'b0, irq}, 8'h00);
    for (int i = 0; i < 7; i++) send_rx(8'h40 + 8'(i), 1'b1);
    repeat (20) @(negedge clk);
    check("irq_below_th", {7'b0, irq}, 8'h00);
    send_rx(8'h47, 1'b1);
    repeat (20) @(negedge clk);
    check("irq_at_th", {7'b0, irq}, 8'h01);
    bus_read(2'd0, rd); check("irq_status", rd, 8'h8F);
    bus_read(2'd1, rd); check("irq_pop_data", rd, 8'h40);
    check("irq_after_pop", {7'b0, irq}, 8'h00);
    bus_write(2'd0, 8'h20);
    check("irq_tx_not_full", {7'b0, irq}, 8'h01);
    bus_write(2'd0, 8'h00);
    check("irq_off", {7'b0, irq}, 8'h00);

    // Master reset in the middle of a frame.
    bus_write(2'd1, 8'hC3);
    bus_write(2'd1, 8'h3C);
    bus_write(2'd1, 8'h99);
    wait_tx_low("mr_tx_start");
    repeat (500) @(negedge clk);
    check("mr_pre_tx", {7'b0, tx}, 8'h00);
    bus_write(2'd0, 8'h03);
    check("mr_tx_high", {7'b0, tx}, 8'h01);
    bus_read(2'd0, rd); check("mr_status", rd, 8'h0A);
    bus_write(2'd0, 8'h00);
    repeat (300) @(negedge clk);
    check("mr_tx_stays", {7'b0, tx}, 8'h01);
    bus_read(2'd0, rd); check("mr_status_after", rd, 8'h0A);
    bus_read(2'd1, rd); check("mr_rx_flushed", rd, 8'h40);

    // Asynchronous reset mid-frame.
    bus_write(2'd0, 8'h20);
    bus_write(2'd1, 8'h0F);
    wait_tx_low("ar_tx_start");
    bus_write(2'd2, 8'h34);
    bus_read(2'd0, rd); check("ar_busy_status", rd, 8'h82);
    check("ar_pre_tx", {7'b0, tx}, 8'h00);
    check("ar_pre_irq", {7'b0, irq}, 8'h01);
    #3;
    rst = 1'b1;
    #1;
    check("ar_dout", dout, 8'h00);
    check("ar_tx", {7'b0, tx}, 8'h01);
    check("ar_irq", {7'b0, irq}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    bus_read(2'd2, rd); check("ar_div_lo", rd, 8'h08);
    bus_read(2'd0, rd); check("ar_status", rd, 8'h0A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
